// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : captures A, B and opcode on load strobes, primes the ALU
//                    opcode lines, waits a settle window and registers ALU F.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int DW     = 2,
  parameter int FW     = 3,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sw_in,
  input  logic [2:0]    op_in,
  input  logic          load,
  input  logic          res_ack,
  output logic          alu_c,
  output logic [1:0]    alu_s,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [FW-1:0] alu_f,
  output logic [FW-1:0] result,
  output logic          res_valid,
  output logic          busy,
  output logic [1:0]    step
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HAVE_A = 3'd1,
    S_HAVE_B = 3'd2,
    S_PRIME  = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q;
  logic [2:0]    opreg_q;
  logic [2:0]    op_lines_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] result_q;
  logic          valid_q;
  logic          busy_q;
  logic [1:0]    step_q;

  // step/busy are updated alongside each transition so they track the state
  // without an extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opreg_q    <= '0;
      op_lines_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      step_q     <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            a_q     <= sw_in;
            state_q <= S_HAVE_A;
            step_q  <= 2'd1;
          end
        end
        S_HAVE_A: begin
          if (load) begin
            b_q     <= sw_in;
            state_q <= S_HAVE_B;
            step_q  <= 2'd2;
          end
        end
        S_HAVE_B: begin
          if (load) begin
            // Drive the complement first so the ALU always sees an opcode edge.
            opreg_q    <= op_in;
            op_lines_q <= ~op_in;
            state_q    <= S_PRIME;
            step_q     <= 2'd3;
            busy_q     <= 1'b1;
          end
        end
        S_PRIME: begin
          op_lines_q <= opreg_q;
          cnt_q      <= CW'(SETTLE - 1);
          state_q    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            result_q <= alu_f;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (load) begin
            valid_q <= 1'b0;
            a_q     <= sw_in;
            state_q <= S_HAVE_A;
            step_q  <= 2'd1;
          end else if (res_ack) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
            step_q  <= 2'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          step_q  <= 2'd0;
        end
      endcase
    end
  end

  assign alu_c     = op_lines_q[2];
  assign alu_s     = op_lines_q[1:0];
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign result    = result_q;
  assign res_valid = valid_q;
  assign busy      = busy_q;
  assign step      = step_q;

endmodule

`default_nettype wire
